// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encodings, default frame constants and line idle level
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } uart_state_t;

  localparam int   DEFAULT_OVERSAMPLE = 16;
  localparam int   DEFAULT_DATA_BITS  = 8;
  localparam logic LINE_IDLE          = 1'b1;

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - two-flop synchronizer for the asynchronous rx line, resets to line idle
module uart_rx_sync
  import uart_pkg::*;
(
  input  logic clk_baud,
  input  logic rst,
  input  logic rx,
  output logic rx_s
);

  logic rx_meta;

  // Two flops in series; both preset to idle so reset never looks like a start bit
  always_ff @(posedge clk_baud) begin
    if (rst) begin
      rx_meta <= LINE_IDLE;
      rx_s    <= LINE_IDLE;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampling 8N1 UART receiver with one-entry valid/ready holding register
module uart_rx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE,
  parameter int DATA_BITS  = DEFAULT_DATA_BITS
) (
  input  logic                 clk_baud,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_byte,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 framing_err,
  output logic                 overrun
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int IDX_W = $clog2(DATA_BITS + 1);

  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  logic                 rx_s;
  uart_state_t          state;
  uart_state_t          state_nxt;
  logic [CNT_W-1:0]     cnt;
  logic [CNT_W-1:0]     cnt_nxt;
  logic [IDX_W-1:0]     bit_idx;
  logic [IDX_W-1:0]     bit_idx_nxt;
  logic [DATA_BITS-1:0] shreg;
  logic [DATA_BITS-1:0] shreg_nxt;
  logic                 deliver;
  logic                 ferr_set;

  uart_rx_sync u_sync (
    .clk_baud (clk_baud),
    .rst      (rst),
    .rx       (rx),
    .rx_s     (rx_s)
  );

  // Frame state, tick counter, bit index and shift register
  always_ff @(posedge clk_baud) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_idx <= bit_idx_nxt;
      shreg   <= shreg_nxt;
    end
  end

  // Frame sequencing: validate start at its centre, then sample every bit centre
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    bit_idx_nxt = bit_idx;
    shreg_nxt   = shreg;
    deliver     = 1'b0;
    ferr_set    = 1'b0;
    case (state)
      IDLE: begin
        if (rx_s != LINE_IDLE) begin
          state_nxt = START;
          cnt_nxt   = '0;
        end
      end
      START: begin
        if (cnt == CNT_HALF) begin
          cnt_nxt = '0;
          if (rx_s == LINE_IDLE) begin
            state_nxt = IDLE;
          end else begin
            state_nxt   = DATA;
            bit_idx_nxt = '0;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      DATA: begin
        if (cnt == CNT_LAST) begin
          cnt_nxt     = '0;
          shreg_nxt   = {rx_s, shreg[DATA_BITS-1:1]};
          bit_idx_nxt = bit_idx + 1'b1;
          if (bit_idx == IDX_LAST) begin
            state_nxt = STOP;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      STOP: begin
        if (cnt == CNT_LAST) begin
          cnt_nxt = '0;
          if (rx_s == LINE_IDLE) begin
            deliver   = 1'b1;
            state_nxt = IDLE;
          end else begin
            ferr_set  = 1'b1;
            state_nxt = WAIT_IDLE;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      WAIT_IDLE: begin
        if (rx_s == LINE_IDLE) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Holding register and one-cycle flags; an accept on the delivery edge reloads in place
  always_ff @(posedge clk_baud) begin
    if (rst) begin
      rx_byte     <= '0;
      rx_valid    <= 1'b0;
      framing_err <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      framing_err <= ferr_set;
      overrun     <= 1'b0;
      if (deliver) begin
        if (!rx_valid || rx_ready) begin
          rx_byte  <= shreg;
          rx_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule
